pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register for the CPU datapath, the successor to the fixed ID/EX-style stage latches. Carries a control field and a data payload between two stages with a valid/ready handshake, stall by back-pressure, and flush (bubble insertion) that zeroes control. Drop-in for ID/EX, EX/MEM and MEM/WB by setting widths; an optional skid buffer gives full throughput with a registered `in_ready_o`.

## Interface
- `CTRL_W`, default 8: width of control field (WB/MEM/EX control bits concatenated); zeroed on bubble/flush.
- `DATA_W`, default 106: width of payload (e.g. data1, data2, extended, rt, rd concatenated); never zeroed except by reset.
- `clk_i` in 1: clock; all state updates on the falling edge, matching the other pipeline stages.
- `rst_i` in 1: asynchronous, active-high reset.
- `flush_i` in 1: discard stage contents and any same-cycle input beat.
- `in_valid_i` in 1: upstream beat valid.
- `in_ready_o` out 1: stage can accept a beat.
- `in_ctrl_i` in CTRL_W: upstream control.
- `in_data_i` in DATA_W: upstream payload.
- `out_valid_o` out 1: output beat valid.
- `out_ready_i` in 1: downstream accepts beat.
- `out_ctrl_o` out CTRL_W: control to next stage; 0 whenever `out_valid_o`=0.
- `out_data_o` out DATA_W: payload to next stage.
- `occupancy_o` out 2: beats held (0..1 without skid, 0..2 with skid).

## Operation
- Accept = `in_valid_i & in_ready_o & ~flush_i`; drain = `out_valid_o & out_ready_i`.
- Main entry (`out_*`): loads on accept when empty or draining; clears valid and ctrl on drain with no refill.
- Bubble rule: whenever main entry is invalid, `out_ctrl_o` = 0; `out_data_o` holds its last value.
- Flush: priority over everything. At the edge, all entries invalid, `out_ctrl_o` = 0, occupancy 0; a beat presented that cycle is dropped. `in_ready_o` is not gated by `flush_i`, so upstream treats the beat as consumed (it is younger and flushed upstream too).
- Simultaneous accept + drain with one entry held: main reloads with new beat, occupancy unchanged.
- Reset mid-operation: identical to flush, asynchronous.

## Timing
- Latency: 1 falling edge from accept to `out_valid_o` (both modes, empty stage).
- Throughput: 1 beat/cycle while `out_ready_i`=1.
- Reset values: `out_valid_o`=0, `out_ctrl_o`=0, `out_data_o`=0, `occupancy_o`=0, `in_ready_o`=1.
- Held beat is stable (ctrl and data unchanged) while `out_valid_o`=1 and `out_ready_i`=0.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: second (skid) entry; `in_ready_o` is a register = skid entry empty. A beat accepted while main is full and not draining goes to skid; skid moves to main on next drain, before any new input; occupancy reaches 2. No combinational path `out_ready_i` -> `in_ready_o`.
- Not defined: single entry; `in_ready_o` = `~out_valid_o | out_ready_i` (combinational); occupancy max 1.

## Structure
- Shared defines header holds `WIDTH`, `R_WIDTH`, `WB_CTRL_WIDTH`, `MEM_CTRL_WIDTH`, `EX_CTRL_WIDTH`; per-stage CTRL_W/DATA_W are derived there as named constants, not literals at instantiation.
- Sub-module `pipe_skid_buf` (one CTRL_W+DATA_W entry + valid), instantiated only under `PIPE_STAGE_SKID_EN`.

## Test plan
- Reset: assert `rst_i` between edges -> all outputs at reset values immediately, `in_ready_o`=1.
- Streaming: 4 beats data 0x1..0x4, ctrl 0xA5, `out_ready_i`=1 -> outputs 0x1..0x4 on consecutive edges, 1-edge latency, occupancy ≤1.
- Stall: beat 0x10 held, `out_ready_i`=0 for 3 cycles -> output stable 0x10; no-skid: `in_ready_o`=0; skid: beat 0x11 accepted into skid, occupancy 2, `in_ready_o`=0, then 0x10, 0x11 in order on release.
- Flush with beat in flight: occupancy 1 (or 2), `flush_i`=1 with `in_valid_i`=1 data 0x20 -> next edge `out_valid_o`=0, `out_ctrl_o`=0, occupancy 0, 0x20 never appears.
- Drain without refill: one beat ctrl 0xFF drained, `in_valid_i`=0 -> `out_valid_o`=0, `out_ctrl_o`=0x00, `out_data_o` retains last payload.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared datapath widths for the CPU pipeline stage registers.
// The per-stage control/payload widths are derived here so that every
// instantiation of pipe_stage_reg picks named constants instead of literals.
//
// Contents:
//   WIDTH, R_WIDTH                      - datapath word / register index width
//   WB/MEM/EX_CTRL_WIDTH                - control group widths per stage
//   ID_EX_*, EX_MEM_*, MEM_WB_*         - derived CTRL_W / DATA_W per stage
// -----------------------------------------------------------------------------
package pipe_stage_reg_pkg;

  localparam int WIDTH          = 32;
  localparam int R_WIDTH        = 5;
  localparam int WB_CTRL_WIDTH  = 2;
  localparam int MEM_CTRL_WIDTH = 2;
  localparam int EX_CTRL_WIDTH  = 4;

  // ID/EX: {WB, MEM, EX} control; {data1, data2, extended, rt, rd} payload
  localparam int ID_EX_CTRL_W  = WB_CTRL_WIDTH + MEM_CTRL_WIDTH + EX_CTRL_WIDTH;
  localparam int ID_EX_DATA_W  = 3 * WIDTH + 2 * R_WIDTH;

  // EX/MEM: {WB, MEM} control; {alu_result, store_data, rd} payload
  localparam int EX_MEM_CTRL_W = WB_CTRL_WIDTH + MEM_CTRL_WIDTH;
  localparam int EX_MEM_DATA_W = 2 * WIDTH + R_WIDTH;

  // MEM/WB: {WB} control; {mem_data, alu_result, rd} payload
  localparam int MEM_WB_CTRL_W = WB_CTRL_WIDTH;
  localparam int MEM_WB_DATA_W = 2 * WIDTH + R_WIDTH;

endpackage : pipe_stage_reg_pkg

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Single-entry skid register (control + payload + valid) used by
// pipe_stage_reg to absorb one beat while the main entry is stalled.
// The whole module exists only when PIPE_STAGE_SKID_EN is defined; in the
// default build the stage has no skid entry and this file is empty.
//
// Ports:
//   clk_i    in  1       clock, state updates on the falling edge
//   rst_i    in  1       asynchronous active-high reset
//   flush_i  in  1       discard the held beat
//   load_i   in  1       capture ctrl_i/data_i
//   unload_i in  1       held beat moved to the main entry
//   ctrl_i   in  CTRL_W  control to capture
//   data_i   in  DATA_W  payload to capture
//   valid_o  out 1       entry holds a beat
//   ctrl_o   out CTRL_W  held control
//   data_o   out DATA_W  held payload
// -----------------------------------------------------------------------------
`ifdef PIPE_STAGE_SKID_EN
module pipe_skid_buf #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 106
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              unload_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_r;

  // Skid entry register: flush wins, then load, then unload.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= 1'b0;
      ctrl_r  <= '0;
      data_r  <= '0;
    end else if (flush_i) begin
      valid_r <= 1'b0;
    end else if (load_i) begin
      valid_r <= 1'b1;
      ctrl_r  <= ctrl_i;
      data_r  <= data_i;
    end else if (unload_i) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid_o = valid_r;
  assign ctrl_o  = ctrl_r;
  assign data_o  = data_r;

endmodule : pipe_skid_buf
`endif

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised pipeline stage register with valid/ready handshake,
// back-pressure stall and flush (bubble insertion zeroes control).
// All state changes on the falling edge of clk_i.
//
// Configuration macro: PIPE_STAGE_SKID_EN
//   defined   - adds a skid entry; in_ready_o is registered (skid empty),
//               occupancy 0..2, no combinational out_ready_i -> in_ready_o.
//   undefined - single entry; in_ready_o = ~out_valid_o | out_ready_i.
//
// Ports:
//   clk_i        in  1       clock (falling-edge state updates)
//   rst_i        in  1       asynchronous active-high reset
//   flush_i      in  1       drop stage contents and same-cycle input beat
//   in_valid_i   in  1       upstream beat valid
//   in_ready_o   out 1       stage can accept a beat
//   in_ctrl_i    in  CTRL_W  upstream control
//   in_data_i    in  DATA_W  upstream payload
//   out_valid_o  out 1       output beat valid
//   out_ready_i  in  1       downstream accepts beat
//   out_ctrl_o   out CTRL_W  control to next stage, 0 when out_valid_o=0
//   out_data_o   out DATA_W  payload to next stage (holds when invalid)
//   occupancy_o  out 2       beats currently held
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  // Main entry registers
  logic              out_valid_r;
  logic [CTRL_W-1:0] out_ctrl_r;
  logic [DATA_W-1:0] out_data_r;

  // Main entry next-state
  logic              main_valid_nxt_s;
  logic [CTRL_W-1:0] main_ctrl_nxt_s;
  logic [DATA_W-1:0] main_data_nxt_s;

  logic              in_ready_s;
  logic              accept_s;
  logic              drain_s;

  // Flushed beats are not accepted even though in_ready_o still shows ready.
  assign accept_s = in_valid_i & in_ready_s & ~flush_i;
  assign drain_s  = out_valid_r & out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [DATA_W-1:0] skid_data_s;
  logic              skid_load_s;
  logic              skid_unload_s;
  logic              skid_valid_nxt_s;
  logic              in_ready_r;

  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .load_i   (skid_load_s),
    .unload_i (skid_unload_s),
    .ctrl_i   (in_ctrl_i),
    .data_i   (in_data_i),
    .valid_o  (skid_valid_s),
    .ctrl_o   (skid_ctrl_s),
    .data_o   (skid_data_s)
  );

  assign in_ready_s = in_ready_r;

  // Main/skid steering. in_ready_r=0 whenever skid is full, so an accept
  // never coincides with a skid unload; the skid beat always refills main
  // before any new input, preserving order.
  always_comb begin
    main_valid_nxt_s = out_valid_r;
    main_ctrl_nxt_s  = out_ctrl_r;
    main_data_nxt_s  = out_data_r;
    skid_load_s      = 1'b0;
    skid_unload_s    = 1'b0;
    if (flush_i) begin
      main_valid_nxt_s = 1'b0;
      main_ctrl_nxt_s  = '0;
    end else if (drain_s && skid_valid_s) begin
      main_valid_nxt_s = 1'b1;
      main_ctrl_nxt_s  = skid_ctrl_s;
      main_data_nxt_s  = skid_data_s;
      skid_unload_s    = 1'b1;
    end else if (accept_s && (!out_valid_r || drain_s)) begin
      main_valid_nxt_s = 1'b1;
      main_ctrl_nxt_s  = in_ctrl_i;
      main_data_nxt_s  = in_data_i;
    end else if (accept_s) begin
      skid_load_s      = 1'b1;
    end else if (drain_s) begin
      main_valid_nxt_s = 1'b0;
      main_ctrl_nxt_s  = '0;
    end else begin
      main_valid_nxt_s = out_valid_r;
    end
  end

  // Skid occupancy after the coming edge, used to pre-compute in_ready_r.
  always_comb begin
    if (flush_i) begin
      skid_valid_nxt_s = 1'b0;
    end else if (skid_load_s) begin
      skid_valid_nxt_s = 1'b1;
    end else if (skid_unload_s) begin
      skid_valid_nxt_s = 1'b0;
    end else begin
      skid_valid_nxt_s = skid_valid_s;
    end
  end

  // Registered ready: high exactly when the skid entry will be empty.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_ready_r <= 1'b1;
    end else begin
      in_ready_r <= ~skid_valid_nxt_s;
    end
  end

  assign occupancy_o = {1'b0, out_valid_r} + {1'b0, skid_valid_s};
`else
  assign in_ready_s = ~out_valid_r | out_ready_i;

  // Single-entry steering: load on accept (only possible when empty or
  // draining), otherwise insert a bubble on drain.
  always_comb begin
    main_valid_nxt_s = out_valid_r;
    main_ctrl_nxt_s  = out_ctrl_r;
    main_data_nxt_s  = out_data_r;
    if (flush_i) begin
      main_valid_nxt_s = 1'b0;
      main_ctrl_nxt_s  = '0;
    end else if (accept_s) begin
      main_valid_nxt_s = 1'b1;
      main_ctrl_nxt_s  = in_ctrl_i;
      main_data_nxt_s  = in_data_i;
    end else if (drain_s) begin
      main_valid_nxt_s = 1'b0;
      main_ctrl_nxt_s  = '0;
    end else begin
      main_valid_nxt_s = out_valid_r;
    end
  end

  assign occupancy_o = {1'b0, out_valid_r};
`endif

  // Main entry register; payload is only cleared by reset.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_r <= 1'b0;
      out_ctrl_r  <= '0;
      out_data_r  <= '0;
    end else begin
      out_valid_r <= main_valid_nxt_s;
      out_ctrl_r  <= main_ctrl_nxt_s;
      out_data_r  <= main_data_nxt_s;
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = out_valid_r;
  assign out_ctrl_o  = out_ctrl_r;
  assign out_data_o  = out_data_r;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. A queue-based model of the stage
// (a FIFO of capacity 1, or 2 with PIPE_STAGE_SKID_EN) predicts every output.
// Inputs change just after the rising edge; the DUT updates on the falling
// edge; outputs are compared 1 time unit after the inputs are driven.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int CW = ID_EX_CTRL_W;
  localparam int DW = ID_EX_DATA_W;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [CW-1:0] m_ctrl_q[$];
  logic [DW-1:0] m_data_q[$];
  logic [DW-1:0] m_last_data = '0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_ctrl_i   (in_ctrl),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_ctrl_o  (out_ctrl),
    .out_data_o  (out_data),
    .occupancy_o (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_ready();
    if (CAP == 2) return (m_ctrl_q.size() < 2);
    else          return (m_ctrl_q.size() == 0) || out_ready;
  endfunction

  // Compare all DUT outputs with the model's view of the stage.
  task automatic check_outputs(input string tag);
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    v = (m_ctrl_q.size() > 0);
    c = v ? m_ctrl_q[0] : '0;
    d = v ? m_data_q[0] : m_last_data;
    check({tag, ".valid"}, 128'(out_valid), 128'(v));
    check({tag, ".ctrl"},  128'(out_ctrl),  128'(c));
    check({tag, ".data"},  128'(out_data),  128'(d));
    check({tag, ".occ"},   128'(occupancy), 128'(m_ctrl_q.size()));
    check({tag, ".ready"}, 128'(in_ready),  128'(m_ready()));
  endtask

  // Model of one falling edge with the currently driven inputs.
  task automatic model_edge();
    logic acc, drn;
    if (flush) begin
      m_ctrl_q.delete();
      m_data_q.delete();
    end else begin
      acc = in_valid && m_ready();
      drn = (m_ctrl_q.size() > 0) && out_ready;
      if (drn) begin
        void'(m_ctrl_q.pop_front());
        void'(m_data_q.pop_front());
      end
      if (acc) begin
        m_ctrl_q.push_back(in_ctrl);
        m_data_q.push_back(in_data);
      end
    end
    if (m_data_q.size() > 0) m_last_data = m_data_q[0];
  endtask

  // One clock: drive inputs after the rising edge, check, then model the fall.
  task automatic cycle(input string tag, input logic v, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs(tag);
    model_edge();
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    m_ctrl_q.delete();
    m_data_q.delete();
    m_last_data = '0;
    check({tag, ".valid"}, 128'(out_valid), 128'(1'b0));
    check({tag, ".ctrl"},  128'(out_ctrl),  128'(0));
    check({tag, ".data"},  128'(out_data),  128'(0));
    check({tag, ".occ"},   128'(occupancy), 128'(0));
    check({tag, ".ready"}, 128'(in_ready),  128'(1'b1));
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  initial begin
    // Power-on reset
    #2;
    check("por.valid", 128'(out_valid), 128'(1'b0));
    check("por.ready", 128'(in_ready),  128'(1'b1));
    check("por.occ",   128'(occupancy), 128'(0));
    rst = 1'b0;

    // Streaming: 4 beats, downstream always ready
    for (int i = 1; i <= 4; i++)
      cycle("stream", 1'b1, 8'hA5, DW'(i), 1'b1, 1'b0);
    cycle("stream_tail", 1'b0, 8'h00, '0, 1'b1, 1'b0);
    cycle("stream_idle", 1'b0, 8'h00, '0, 1'b1, 1'b0);

    // Stall: 0x10 held, 0x11 offered while downstream stalls, then release
    cycle("stall_load", 1'b1, 8'h3C, DW'(16'h10), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle("stall_hold", 1'b1, 8'h3D, DW'(16'h11), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle("stall_rel", 1'b0, 8'h00, '0, 1'b1, 1'b0);

    // Flush with beats in flight and a same-cycle beat 0x20
    cycle("fl_fill1", 1'b1, 8'h11, DW'(16'h30), 1'b0, 1'b0);
    cycle("fl_fill2", 1'b1, 8'h12, DW'(16'h31), 1'b0, 1'b0);
    cycle("fl_flush", 1'b1, 8'h13, DW'(16'h20), 1'b0, 1'b1);
    cycle("fl_after", 1'b0, 8'h00, '0, 1'b1, 1'b0);
    cycle("fl_after2", 1'b0, 8'h00, '0, 1'b1, 1'b0);

    // Drain without refill: ctrl cleared, payload retained
    cycle("drain_load", 1'b1, 8'hFF, DW'(32'hCAFE_0042), 1'b1, 1'b0);
    cycle("drain_go", 1'b0, 8'h00, '0, 1'b1, 1'b0);
    cycle("drain_idle", 1'b0, 8'h00, '0, 1'b0, 1'b0);

    // Reset while holding data mid-operation
    cycle("rst_fill", 1'b1, 8'h5A, DW'(32'h1234_5678), 1'b0, 1'b0);
    cycle("rst_fill2", 1'b1, 8'h5B, DW'(32'h1234_5679), 1'b0, 1'b0);
    pulse_reset("rst_mid");
    cycle("rst_after", 1'b0, 8'h00, '0, 1'b1, 1'b0);

    // Randomized traffic, with one reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) pulse_reset("rand_rst");
      cycle("rand", 1'($urandom_range(0, 3) != 0), CW'($urandom), rand_data(),
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 24) == 0));
    end
    cycle("final", 1'b0, 8'h00, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_reg
